// File: rtl/trap_pkg.sv
// Shared encodings for the trap/CSR sequencer: op codes, interrupt causes, FSM and grant enums.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trap_pkg;

  localparam logic [2:0] OP_EXC  = 3'b000;
  localparam logic [2:0] OP_MRET = 3'b001;
  localparam logic [2:0] OP_RW   = 3'b101;
  localparam logic [2:0] OP_RS   = 3'b110;
  localparam logic [2:0] OP_RC   = 3'b111;

  // Interrupt cause as presented on csr_addr_exception: {bit4=interrupt, [3:0]=code}.
  localparam logic [11:0] CAUSE_MEI = 12'h01B;
  localparam logic [11:0] CAUSE_MSI = 12'h013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_EXC,
    GNT_IRQ,
    GNT_CORE
  } gnt_t;

endpackage

// File: rtl/trap_ctrl_arb.sv
// Fixed-priority select between core exception, interrupt entry and other core requests.
// Latency: combinational, result valid in the same cycle as its inputs.
// Backpressure: none; the caller decides whether the selected grant is taken.
module trap_ctrl_arb
  import trap_pkg::*;
(
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic [2:0]  irq_en,
  input  logic        irq_window,
  output gnt_t        gnt,
  output logic [11:0] irq_cause
);

  logic irq_ok;
  logic ext_pend;
  logic sw_pend;

  assign irq_ok   = irq_window & irq_en[2];
  assign ext_pend = irq_ok & irq_ext & irq_en[1];
  assign sw_pend  = irq_ok & irq_sw & irq_en[0];

  // Exceptions pre-empt interrupts (the faulting instruction must not retire);
  // external interrupts beat software ones; ordinary CSR ops go last.
  always_comb begin
    gnt       = GNT_NONE;
    irq_cause = '0;
    if (req_valid && (req_op == OP_EXC)) begin
      gnt = GNT_EXC;
    end else if (ext_pend) begin
      gnt       = GNT_IRQ;
      irq_cause = CAUSE_MEI;
    end else if (sw_pend) begin
      gnt       = GNT_IRQ;
      irq_cause = CAUSE_MSI;
    end else if (req_valid) begin
      gnt = GNT_CORE;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Sequences core CSR ops, exceptions and interrupt entry onto the CSR unit's available/busy handshake.
// Latency: req_ready to rsp_valid is 4 cycles; one operation per 5 cycles.
// Backpressure: losing or non-IDLE core requests see req_ready low and must hold; rsp is a fire-and-forget pulse.
// Build option: TRAP_CTRL_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on ISSUE/WAIT.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic [2:0]  irq_en,
  input  logic        irq_window,
  input  logic [31:0] irq_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        rsp_irq,
  output logic        ctrl_busy,
  output logic        csr_available,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr_exception,
  output logic [31:0] csr_write_value,
  input  logic [31:0] csr_read_value,
  input  logic        csr_busy,
  input  logic        csr_fault
);

  if (TIMEOUT_CYCLES < 4) begin : g_timeout_range
    $error("trap_ctrl: TIMEOUT_CYCLES must be at least 4");
  end

  state_t      state;
  state_t      state_nxt;
  gnt_t        gnt;
  logic [11:0] irq_cause;
  logic        irq_flag;
  logic        load;
  logic        capture;
  logic        tmo_hit;
  logic        tmo_fire;

  trap_ctrl_arb u_arb (
    .req_valid  (req_valid),
    .req_op     (req_op),
    .irq_ext    (irq_ext),
    .irq_sw     (irq_sw),
    .irq_en     (irq_en),
    .irq_window (irq_window),
    .gnt        (gnt),
    .irq_cause  (irq_cause)
  );

`ifdef TRAP_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Count cycles spent in ISSUE/WAIT for the current operation, restarting at each grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (load) begin
      tmo_cnt <= '0;
    end else if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Counter is 0 in the first ISSUE cycle, so RELEASE lands exactly TIMEOUT_CYCLES after issue.
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; completion takes precedence over a coincident timeout.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    tmo_fire  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_irq   = 1'b0;
    ctrl_busy = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (gnt != GNT_NONE) begin
          load      = 1'b1;
          state_nxt = ST_ISSUE;
          // Gated by reset_n so req_ready is low while reset is held.
          req_ready = reset_n && ((gnt == GNT_EXC) || (gnt == GNT_CORE));
        end
      end
      ST_ISSUE: begin
        if (csr_busy) begin
          state_nxt = ST_WAIT;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_WAIT: begin
        if (!csr_busy) begin
          capture   = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        rsp_valid = 1'b1;
        rsp_irq   = irq_flag;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered CSR drive and response capture; csr_fault is only valid in the busy-low cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_available      <= 1'b0;
      csr_op             <= '0;
      csr_addr_exception <= '0;
      csr_write_value    <= '0;
      rsp_rdata          <= '0;
      rsp_fault          <= 1'b0;
      irq_flag           <= 1'b0;
    end else if (load) begin
      csr_available <= 1'b1;
      if (gnt == GNT_IRQ) begin
        csr_op             <= OP_EXC;
        csr_addr_exception <= irq_cause;
        csr_write_value    <= irq_pc;
        irq_flag           <= 1'b1;
      end else begin
        csr_op             <= req_op;
        csr_addr_exception <= req_addr;
        csr_write_value    <= req_wdata;
        irq_flag           <= 1'b0;
      end
    end else if (capture) begin
      csr_available <= 1'b0;
      rsp_rdata     <= csr_read_value;
      rsp_fault     <= csr_fault;
    end else if (tmo_fire) begin
      csr_available <= 1'b0;
      rsp_rdata     <= '0;
      rsp_fault     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small CSR-unit responder model.
// Latency: checks the 4-cycle request-to-response timing cycle by cycle.
// Backpressure: exercises held/losing requests and back-to-back grants.
module tb_trap_ctrl;
  import trap_pkg::*;

  localparam logic [31:0] MTVEC = 32'h0000_0100;
  localparam logic [31:0] MEPC  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        irq_ext;
  logic        irq_sw;
  logic [2:0]  irq_en;
  logic        irq_window;
  logic [31:0] irq_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        rsp_irq;
  logic        ctrl_busy;
  logic        csr_available;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exception;
  logic [31:0] csr_write_value;
  logic [31:0] csr_read_value;
  logic        csr_busy;
  logic        csr_fault;

  int   checks = 0;
  int   errors = 0;
  logic stuck  = 1'b0;
  logic [1:0] m_st;

  always #5 clk = ~clk;

  trap_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_op             (req_op),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_ready          (req_ready),
    .irq_ext            (irq_ext),
    .irq_sw             (irq_sw),
    .irq_en             (irq_en),
    .irq_window         (irq_window),
    .irq_pc             (irq_pc),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_fault          (rsp_fault),
    .rsp_irq            (rsp_irq),
    .ctrl_busy          (ctrl_busy),
    .csr_available      (csr_available),
    .csr_op             (csr_op),
    .csr_addr_exception (csr_addr_exception),
    .csr_write_value    (csr_write_value),
    .csr_read_value     (csr_read_value),
    .csr_busy           (csr_busy),
    .csr_fault          (csr_fault)
  );

  // CSR unit behaviour: {fault, read value} for an op/address.
  function automatic logic [32:0] csr_model(input logic [2:0] op, input logic [11:0] a);
    if (op == OP_EXC)  return {1'b0, MTVEC};
    if (op == OP_MRET) return {1'b0, MEPC};
    if (op == 3'b010 || op == 3'b011 || op == 3'b100) return {1'b1, 32'h0};
    if (a == 12'h300) return {1'b0, 32'h0};
    if (a == 12'h305 && op == OP_RW) return {1'b1, 32'h0};
    if (a == 12'h305) return {1'b0, MTVEC};
    if (a == 12'h7C0) return {1'b1, 32'h0};
    return {1'b0, 20'hCAFE0, a};
  endfunction

  // CSR unit responder: busy one cycle after available, then a single result cycle, then DONE until released.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= 2'd0; csr_busy <= 1'b0; csr_read_value <= '0; csr_fault <= 1'b0;
    end else begin
      case (m_st)
        2'd0: if (csr_available && !stuck) begin csr_busy <= 1'b1; m_st <= 2'd1; end
        2'd1: begin
          csr_busy <= 1'b0;
          {csr_fault, csr_read_value} <= csr_model(csr_op, csr_addr_exception);
          m_st <= 2'd2;
        end
        default: begin
          csr_fault <= 1'b0; csr_read_value <= '0;
          if (!csr_available) m_st <= 2'd0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive a core request at a sample point and expect it to be accepted this cycle.
  task automatic core_grant(input string name, input logic [2:0] op, input logic [11:0] a,
                            input logic [31:0] wd, input logic hold);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s grant: req_ready=%b expected 1", name, req_ready);
    end
    tick();
    if (!hold) req_valid = 1'b0;
  endtask

  // Follow one granted operation from T+1 to T+5.
  task automatic run_op(input string name, input logic [2:0] e_op, input logic [11:0] e_addr,
                        input logic [31:0] e_wd, input logic [31:0] e_rd, input logic e_fault,
                        input logic e_irq);
    checks++;
    if ({csr_available, csr_op, csr_addr_exception, csr_write_value} !== {1'b1, e_op, e_addr, e_wd}) begin
      errors++;
      $display("FAIL %s issue: avail=%b op=%b addr=%h wv=%h expected 1 %b %h %h",
               name, csr_available, csr_op, csr_addr_exception, csr_write_value, e_op, e_addr, e_wd);
    end
    tick(); tick();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b00) begin
      errors++; $display("FAIL %s T+3: rsp_valid=%b req_ready=%b expected 0 0", name, rsp_valid, req_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_irq, rsp_fault, rsp_rdata} !== {1'b1, e_irq, e_fault, e_rd}) begin
      errors++;
      $display("FAIL %s rsp: valid=%b irq=%b fault=%b rdata=%h expected 1 %b %b %h",
               name, rsp_valid, rsp_irq, rsp_fault, rsp_rdata, e_irq, e_fault, e_rd);
    end
    tick();
    checks++;
    if ({rsp_valid, ctrl_busy} !== 2'b00) begin
      errors++; $display("FAIL %s T+5: rsp_valid=%b busy=%b expected 0 0", name, rsp_valid, ctrl_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; req_op = OP_EXC; req_addr = 12'h002; req_wdata = 32'h44;
    irq_ext = 1'b0; irq_sw = 1'b0; irq_en = 3'b000; irq_window = 1'b0; irq_pc = '0;
    #3;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_irq, ctrl_busy, csr_available,
         csr_op, csr_addr_exception, csr_write_value} !== 85'd0) begin
      errors++; $display("FAIL reset outputs: req_ready=%b busy=%b avail=%b expected all 0",
                         req_ready, ctrl_busy, csr_available);
    end
    tick(); tick();
    req_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++;
    if ({ctrl_busy, csr_available} !== 2'b00) begin
      errors++; $display("FAIL reset release idle: busy=%b avail=%b expected 0 0", ctrl_busy, csr_available);
    end
  endtask

  task automatic test_csrrs_back_to_back();
    core_grant("csrrs300", OP_RS, 12'h300, 32'h8, 1'b1);
    req_op = OP_RC; req_addr = 12'h342; req_wdata = 32'h3;
    run_op("csrrs300", OP_RS, 12'h300, 32'h8, 32'h0, 1'b0, 1'b0);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b T+5 grant: req_ready=%b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    run_op("csrrc342", OP_RC, 12'h342, 32'h3, 32'hCAFE_0342, 1'b0, 1'b0);
  endtask

  task automatic test_irq_priority();
    req_valid = 1'b1; req_op = OP_RW; req_addr = 12'h340; req_wdata = 32'h55;
    irq_ext = 1'b1; irq_en = 3'b111; irq_window = 1'b1; irq_pc = 32'h1234;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL irq beats core: req_ready=%b expected 0", req_ready);
    end
    tick();
    irq_ext = 1'b0; irq_window = 1'b0;
    run_op("irq_ext", OP_EXC, CAUSE_MEI, 32'h1234, MTVEC, 1'b0, 1'b1);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL core after irq: req_ready=%b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    run_op("csrrw340", OP_RW, 12'h340, 32'h55, 32'hCAFE_0340, 1'b0, 1'b0);
  endtask

  task automatic test_exc_over_irq();
    irq_sw = 1'b1; irq_en = 3'b111; irq_window = 1'b1; irq_pc = 32'h9999;
    core_grant("exc002", OP_EXC, 12'h002, 32'h800, 1'b0);
    irq_sw = 1'b0; irq_window = 1'b0;
    run_op("exc002", OP_EXC, 12'h002, 32'h800, MTVEC, 1'b0, 1'b0);
  endtask

  task automatic test_sw_irq();
    irq_sw = 1'b1; irq_en = 3'b111; irq_window = 1'b1; irq_pc = 32'h4000;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL sw irq no ready: req_ready=%b expected 0", req_ready);
    end
    tick();
    irq_sw = 1'b0; irq_window = 1'b0;
    run_op("irq_sw", OP_EXC, CAUSE_MSI, 32'h4000, MTVEC, 1'b0, 1'b1);
  endtask

  task automatic test_irq_masked();
    irq_ext = 1'b1; irq_sw = 1'b1; irq_en = 3'b011; irq_window = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (ctrl_busy !== 1'b0) begin
      errors++; $display("FAIL irq MIE=0 taken: busy=%b expected 0", ctrl_busy);
    end
    irq_en = 3'b111; irq_window = 1'b0;
    tick(); tick();
    checks++;
    if (ctrl_busy !== 1'b0) begin
      errors++; $display("FAIL irq outside window taken: busy=%b expected 0", ctrl_busy);
    end
    irq_ext = 1'b0; irq_sw = 1'b0; irq_en = 3'b000;
  endtask

  task automatic test_faults();
    core_grant("csrrw305", OP_RW, 12'h305, 32'h200, 1'b0);
    run_op("csrrw305", OP_RW, 12'h305, 32'h200, 32'h0, 1'b1, 1'b0);
    core_grant("csrrs7c0", OP_RS, 12'h7C0, 32'h1, 1'b0);
    run_op("csrrs7c0", OP_RS, 12'h7C0, 32'h1, 32'h0, 1'b1, 1'b0);
    core_grant("illegal010", 3'b010, 12'h300, 32'h0, 1'b0);
    run_op("illegal010", 3'b010, 12'h300, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_mret();
    core_grant("mret", OP_MRET, 12'h000, 32'h0, 1'b0);
    run_op("mret", OP_MRET, 12'h000, 32'h0, MEPC, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    core_grant("rst_mid", OP_RS, 12'h300, 32'h8, 1'b0);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_irq, ctrl_busy, csr_available,
         csr_op, csr_addr_exception, csr_write_value} !== 85'd0) begin
      errors++; $display("FAIL reset in WAIT: busy=%b avail=%b op=%b rdata=%h expected all 0",
                         ctrl_busy, csr_available, csr_op, rsp_rdata);
    end
    tick(); tick();
    checks++;
    if ({rsp_valid, ctrl_busy} !== 2'b00) begin
      errors++; $display("FAIL reset hold: rsp_valid=%b busy=%b expected 0 0", rsp_valid, ctrl_busy);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL dropped op responded: rsp_valid=%b expected 0", rsp_valid);
    end
    core_grant("post_rst", OP_RC, 12'h341, 32'h0, 1'b0);
    run_op("post_rst", OP_RC, 12'h341, 32'h0, 32'hCAFE_0341, 1'b0, 1'b0);
  endtask

`ifdef TRAP_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    stuck = 1'b1;
    core_grant("timeout", OP_RW, 12'h340, 32'h1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({rsp_valid, csr_available} !== 2'b01) begin
      errors++; $display("FAIL timeout early: rsp_valid=%b avail=%b expected 0 1", rsp_valid, csr_available);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata, csr_available} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL timeout rsp: valid=%b fault=%b rdata=%h avail=%b expected 1 1 0 0",
                         rsp_valid, rsp_fault, rsp_rdata, csr_available);
    end
    tick();
    stuck = 1'b0;
    checks++;
    if (ctrl_busy !== 1'b0) begin
      errors++; $display("FAIL timeout idle: busy=%b expected 0", ctrl_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_csrrs_back_to_back();
    test_irq_priority();
    test_exc_over_irq();
    test_sw_irq();
    test_irq_masked();
    test_faults();
    test_mret();
    test_reset_mid_op();
`ifdef TRAP_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Sequencer and arbiter in front of the machine-level CSR unit. It multiplexes three requester classes onto the CSR unit's single available/busy handshake: core instructions (CSRRW/RS/RC, MRET), synchronous exceptions, and asynchronous interrupt entry. It drives each granted operation to completion and returns a one-cycle response to the core.

## Interface
- TIMEOUT_CYCLES, 8: cycles allowed from issue to CSR completion (used only with TRAP_CTRL_TIMEOUT_EN); minimum 4.
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous assert, active-low (fixed)
- req_valid  in  1  core request pending; held stable until req_ready
- req_op  in  3  000=exception, 001=MRET, 101/110/111=CSRRW/RS/RC
- req_addr  in  12  CSR address, or exception cause {bit4=interrupt, [3:0]=code}
- req_wdata  in  32  CSR write value, or faulting PC for exceptions
- req_ready  out  1  one-cycle accept pulse
- irq_ext, irq_sw  in  1 each  level interrupt lines
- irq_en  in  3  [2]=global MIE, [1]=MEIE, [0]=MSIE (core-maintained mirror)
- irq_window  in  1  core at instruction boundary; interrupt may be taken
- irq_pc  in  32  PC saved on interrupt entry
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  CSR read value, or redirect target for exceptions, interrupts and MRET
- rsp_fault  out  1  CSR fault or timeout
- rsp_irq  out  1  response belongs to an interrupt entry, not to a core request
- ctrl_busy  out  1  state != IDLE
- csr_available, csr_op[2:0], csr_addr_exception[11:0], csr_write_value[31:0]  out  registered drive to the CSR unit
- csr_read_value[31:0], csr_busy, csr_fault  in  from the CSR unit

## Operation
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE arbitration, fixed priority:
  1. Core exception: req_valid & req_op==000.
  2. Interrupt: irq_window & irq_en[2] & ((irq_ext & irq_en[1]) | (irq_sw & irq_en[0])). External beats software.
  3. Any other core request.
- Losing core requests see no req_ready and must hold their request.
- Grant latches op, addr and wdata into the csr_* registers and moves to ISSUE. req_ready pulses only for core grants.
- Interrupt grant drives csr_op=000, csr_write_value=irq_pc, and csr_addr_exception=12'h01B (external, cause 11) or 12'h013 (software, cause 3). It sets the internal irq flag.
- ISSUE: csr_available=1. Wait for csr_busy=1, then WAIT.
- WAIT: on csr_busy=0:
  - capture csr_read_value into rsp_rdata and csr_fault into rsp_fault;
  - clear csr_available;
  - go to RELEASE.
- RELEASE: rsp_valid=1 for exactly one cycle, rsp_irq=irq flag, then IDLE.
- Illegal op codes (010, 011, 100) are forwarded unchanged. The CSR unit faults them and rsp_fault=1.
- Reset, at any state including mid-operation:
  - state=IDLE;
  - all outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_irq, ctrl_busy, csr_available, csr_op, csr_addr_exception, csr_write_value.
- Reset mid-operation drops the in-flight operation; no response is produced. The CSR unit shares reset_n and returns to idle too.

## Timing
- Grant in cycle T. csr_available=1 in T+1. csr_busy=1 in T+2. csr_busy=0 with result valid in T+3. rsp_valid in T+4. Next grant possible in T+5.
- Latency from req_ready to rsp_valid is 4 cycles; throughput is one operation per 5 cycles.
- csr_fault is valid only during the csr_busy=0 cycle, so capture must happen in that cycle.
- csr_available is low during RELEASE, so the CSR unit leaves DONE before the next issue.
- Interrupt inputs are sampled only in IDLE. A deassert after grant does not cancel the entry.

## Configuration
- TRAP_CTRL_TIMEOUT_EN defined:
  - a counter runs in ISSUE/WAIT;
  - if it reaches TIMEOUT_CYCLES without completion: clear csr_available, go to RELEASE, and respond with rsp_fault=1, rsp_rdata=0.
- Undefined: no counter; ISSUE/WAIT wait indefinitely.

## Structure
- trap_pkg holds:
  - op encodings (OP_EXC, OP_MRET, OP_RW, OP_RS, OP_RC);
  - cause constants (CAUSE_MEI=12'h01B, CAUSE_MSI=12'h013);
  - FSM state enum.
- Sub-module trap_ctrl_arb: combinational priority select producing grant class and cause. The FSM and the registered CSR drive stay in trap_ctrl.

## Test plan
- CSRRS addr 0x300, wdata 0x8, MIE=0 -> req_ready at T, rsp_valid at T+4 with rsp_rdata=0x0, rsp_fault=0; next grant no earlier than T+5.
- irq_ext=1, irq_en=3'b111, irq_window=1 while core holds CSRRW -> interrupt first: csr_addr_exception=0x01B, csr_write_value=irq_pc=0x1234, rsp_irq=1, rsp_rdata=IRQ handler address. CSRRW then accepted in the following IDLE.
- Simultaneous exception (req_op=000, cause 0x002) and irq_sw pending -> exception granted, rsp_irq=0, rsp_fault=0.
- CSRRW to 0x305 -> rsp_fault=1. CSRRS to 0x7C0 -> rsp_fault=1, rsp_rdata=0.
- reset_n low during WAIT -> all outputs 0 immediately, no rsp_valid. A fresh request after release completes normally.
- With TRAP_CTRL_TIMEOUT_EN and csr_busy stuck low -> rsp_valid with rsp_fault=1 exactly TIMEOUT_CYCLES after issue.
